// File: rtl/serial_adder.sv
// Bit-serial adder: loads two WIDTH-bit operands and a carry-in, adds one bit per clock.
// Optional macro SERIAL_ADDER_OVF_EN adds a two's-complement overflow output (ovf).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             carry
);

    // state | meaning
    // IDLE  | waiting for start, last result held
    // SHIFT | one operand bit added per edge
    // DONE  | result just committed; start here chains the next add
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, work_q, sum_q;
    logic             cy_q, carry_q, done_q;
    logic             accept, last, s_bit, cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    assign accept = start && (state_q != SHIFT);
    assign last   = (state_q == SHIFT) && (cnt_q == LAST);
    assign s_bit  = a_q[0] ^ b_q[0] ^ cy_q;
    assign cout   = (a_q[0] & b_q[0]) | (a_q[0] & cy_q) | (b_q[0] & cy_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last)  state_d = DONE;
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SHIFT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cy_q    <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            // done is registered off DONE, so it trails the result commit by one edge
            done_q <= (state_q == DONE);
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                cy_q  <= c_in;
                cnt_q <= '0;
            end else if (state_q == SHIFT) begin
                a_q    <= a_q >> 1;
                b_q    <= b_q >> 1;
                cy_q   <= cout;
                work_q <= {s_bit, work_q[WIDTH-1:1]};
                cnt_q  <= cnt_q + CW'(1);
                if (last) begin
                    sum_q   <= {s_bit, work_q[WIDTH-1:1]};
                    carry_q <= cout;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_q   <= cy_q ^ cout;
`endif
                end
            end
        end
    end

    assign done  = done_q;
    assign sum   = sum_q;
    assign carry = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 directed vectors plus an exhaustive WIDTH=2 instance.
module tb_serial_adder;

    logic       clk, rst;
    logic       start, c_in, busy, done, carry;
    logic [7:0] a, b, sum;
    logic       start2, c_in2, busy2, done2, carry2;
    logic [1:0] a2, b2, sum2;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf, ovf2;
`endif

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
        .busy(busy), .done(done), .sum(sum),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf),
`endif
        .carry(carry)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .c_in(c_in2),
        .busy(busy2), .done(done2), .sum(sum2),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf2),
`endif
        .carry(carry2)
    );

    typedef struct {
        logic [8:0] res;
        logic       ovf;
        int         due;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [8:0] res;
        logic       ovf;
    } vec_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    vec_t vecs[8];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // WIDTH=8 monitor: result, timing and optional overflow
    always @(negedge clk) begin
        if (done) begin
            if (q1.size() == 0) begin
                check("unexpected_done_w8", 1, 0);
            end else begin
                e1 = q1.pop_front();
                check("result_w8", int'({carry, sum}), int'(e1.res));
                check("done_cycle_w8", cyc, e1.due);
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf_w8", int'(ovf), int'(e1.ovf));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (done2) begin
            if (q2.size() == 0) begin
                check("unexpected_done_w2", 1, 0);
            end else begin
                e2 = q2.pop_front();
                check("result_w2", int'({carry2, sum2}), int'(e2.res[2:0]));
                check("done_cycle_w2", cyc, e2.due);
            end
        end
    end

    // Called at a negedge; returns at a negedge with the DUT back in IDLE.
    task automatic issue(input vec_t v, input bit push, output int nbusy);
        a = v.a; b = v.b; c_in = v.ci; start = 1'b1;
        if (push) q1.push_back('{v.res, v.ovf, cyc + 10});
        @(negedge clk);
        start = 1'b0;
        a = ~v.a; b = ~v.b; c_in = ~v.ci;
        nbusy = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge clk);
        check("drain_w8", q1.size(), 0);
        check("drain_w2", q2.size(), 0);
    endtask

    initial begin
        int nb;
        //          a      b      ci    {carry,sum}  ovf
        vecs[0] = '{8'h0F, 8'h01, 1'b0, 9'h010, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 9'h100, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 9'h080, 1'b1};
        vecs[4] = '{8'hA5, 8'h5A, 1'b1, 9'h100, 1'b0};
        vecs[5] = '{8'h3C, 8'hC3, 1'b0, 9'h0FF, 1'b0};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 9'h100, 1'b1};
        vecs[7] = '{8'h12, 8'h34, 1'b1, 9'h047, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; c_in2 = 1'b0;
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_sum", int'(sum), 0);
        check("reset_carry", int'(carry), 0);

        // start in the same cycle reset is released: accepted at the first edge
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            issue(vecs[k], 1'b1, nb);
            check("busy_cycles", nb, 8);
            check("result_held_idle", int'({carry, sum}), int'(vecs[k].res));
        end

        // back-to-back with start held and operands scrambled every cycle
        for (int k = 4; k < 8; k++) begin
            a = vecs[k].a; b = vecs[k].b; c_in = vecs[k].ci; start = 1'b1;
            q1.push_back('{vecs[k].res, vecs[k].ovf, cyc + 10});
            for (int j = 1; j <= 9; j++) begin
                @(negedge clk);
                if (k == 7 && j == 1) start = 1'b0;
                a = 8'(cyc * 37); b = 8'(cyc * 11); c_in = cyc[0];
            end
        end
        drain();

        // abort three cycles into SHIFT
        a = vecs[0].a; b = vecs[0].b; c_in = vecs[0].ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_sum", int'(sum), 0);
        check("abort_carry", int'(carry), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(vecs[2], 1'b1, nb);
        check("busy_after_abort", nb, 8);

        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                for (int c = 0; c < 2; c++) begin
                    a2 = 2'(x); b2 = 2'(y); c_in2 = c[0]; start2 = 1'b1;
                    q2.push_back('{9'(x + y + c), 1'b0, cyc + 4});
                    @(negedge clk);
                    start2 = 1'b0;
                    a2 = ~a2; b2 = ~b2; c_in2 = ~c_in2;
                    repeat (3) @(negedge clk);
                end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result bit count (legal range 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset. Asynchronous, active-high. This is the only reset.
REQ-004 SHALL have port start  input  1  request to load operands and begin a bit-serial add.
REQ-005 SHALL have port a  input  WIDTH  operand A, sampled only when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  operand B, sampled only when start is accepted.
REQ-007 SHALL have port c_in  input  1  carry-in, sampled only when start is accepted.
REQ-008 SHALL have port busy  output  1  high while bits are being processed.
REQ-009 SHALL have port done  output  1  single-cycle pulse marking a new valid result.
REQ-010 SHALL have port sum  output  WIDTH  registered result, a+b+c_in mod 2^WIDTH.
REQ-011 SHALL have port carry  output  1  registered carry-out of the full WIDTH-bit add.

Function
REQ-012 SHALL implement states IDLE, SHIFT and DONE.
REQ-013 Start acceptance SHALL occur at a rising edge where start=1 and state is IDLE or DONE.
REQ-014 On acceptance, the block SHALL load a and b into shift registers and c_in into the carry flop, clear the bit counter, and enter SHIFT.
REQ-015 Each SHIFT edge SHALL full-add the operand LSBs with the carry flop, shift the sum bit into a working register MSB-first-in, update the carry flop and shift both operands right by one.
REQ-016 After exactly WIDTH SHIFT edges, the block SHALL copy the working register to sum and the carry flop to carry, and enter DONE.
REQ-017 Latency SHALL be fixed: if start is accepted at edge t, done=1 during the cycle after edge t+WIDTH+1, lasting exactly one cycle.
REQ-018 DONE SHALL go to IDLE on the next edge unless start=1, in which case it SHALL go to SHIFT (back-to-back operation, no idle gap).
REQ-019 start during SHIFT SHALL be ignored, with no effect on operands, counter or result.
REQ-020 busy SHALL be 1 exactly when state is SHIFT.
REQ-021 sum and carry SHALL change only at the completion edge (REQ-016) or reset, and SHALL hold the last result otherwise, including through IDLE.
REQ-022 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during an operation.
REQ-023 Changes on a, b or c_in after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-024 Asserting rst SHALL, without waiting for a clock edge, force state=IDLE, busy=0, done=0, sum=0, carry=0, and clear the counter, the shift registers and the carry flop.
REQ-025 rst asserted mid-SHIFT SHALL abort the operation with no done pulse and no partial result on sum.
REQ-026 The first start SHALL be accepted at the first rising edge after rst deasserts.

Configuration
REQ-027 Macro SERIAL_ADDER_OVF_EN SHALL, when defined, add output port ovf (1 bit), reset 0, updated only at the completion edge with two's-complement overflow: carry into MSB XOR carry out of MSB.
REQ-028 Without SERIAL_ADDER_OVF_EN, port ovf and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-029 WIDTH=8, a=8'h0F, b=8'h01, c_in=0, pulse start -> busy for 8 cycles, then done pulse, sum=8'h10, carry=0.
REQ-030 a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, carry=1. a=8'hFF, b=8'hFF, c_in=1 -> sum=8'hFF, carry=1.
REQ-031 start=1 held continuously, with operands changed each cycle -> one done every 9 cycles, each result matching the operands sampled at its acceptance edge.
REQ-032 Assert rst 3 cycles into SHIFT -> outputs zero immediately, no done pulse; a fresh add after reset gives the correct result.
REQ-033 With SERIAL_ADDER_OVF_EN: a=8'h7F, b=8'h01 -> sum=8'h80, ovf=1. a=8'hFF, b=8'h01 -> ovf=0.
REQ-034 Exhaustive check at WIDTH=2 (all a, b, c_in combinations) -> {carry,sum} equals a+b+c_in in every case.
